// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rr_arb_func_pkg.sv
// Shared types and constants for the round-robin arbiter.
// State encoding, default sizes and a one-hot to index helper.
package gf180mcu_fd_sc_mcu9t5v0__arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int ARB_N        = 4;
   localparam int ARB_N_MAX    = 8;
   localparam int ARB_MAX_HOLD = 16;

   // Widest supported requester set is 8, so a fixed 8-bit view suffices.
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) begin
            idx = idx | 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rr_arb_func_if.sv
// Request/grant bundle between requesters (master) and arbiter (slave).
interface gf180mcu_fd_sc_mcu9t5v0__rr_arb_func_if
   import gf180mcu_fd_sc_mcu9t5v0__arb_pkg::*;
#(
   parameter int N    = ARB_N,
   parameter int IDXW = $clog2(ARB_N)
);

   logic [N-1:0]    REQ;
   logic            LAST;
   logic [N-1:0]    GNT;
   logic            GNT_VLD;
   logic [IDXW-1:0] GNT_IDX;
   logic            TIMEOUT;

   modport master (
      output REQ,
      output LAST,
      input  GNT,
      input  GNT_VLD,
      input  GNT_IDX,
      input  TIMEOUT
   );

   modport slave (
      input  REQ,
      input  LAST,
      output GNT,
      output GNT_VLD,
      output GNT_IDX,
      output TIMEOUT
   );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rr_pick_func.sv
// Combinational rotate-priority picker: first set request
// scanning from i_ptr upward, wrapping modulo N.
module gf180mcu_fd_sc_mcu9t5v0__rr_pick_func
   import gf180mcu_fd_sc_mcu9t5v0__arb_pkg::*;
#(
   parameter int N    = ARB_N,
   parameter int IDXW = $clog2(ARB_N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [N-1:0]    o_oh,
   output logic [IDXW-1:0] o_idx,
   output logic            o_any
);

   logic [N-1:0] w_oh;
   logic         w_any;

   function automatic logic [IDXW-1:0] rot(
      input logic [IDXW-1:0] p,
      input int              k
   );
      int s;
      s = int'(p) + k;
      if (s >= N) begin
         s = s - N;
      end
      return IDXW'(s);
   endfunction

   always_comb begin
      w_oh  = '0;
      w_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!w_any && i_req[rot(i_ptr, k)]) begin
            w_oh[rot(i_ptr, k)] = 1'b1;
            w_any               = 1'b1;
         end
      end
   end

   assign o_oh  = w_oh;
   assign o_any = w_any;
   assign o_idx = IDXW'(oh2idx(8'(w_oh)));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rr_arb_func.sv
// Round-robin arbiter, registered one-hot grant locked until release.
// Define GF180MCU_FD_SC_MCU9T5V0__RR_ARB_TIMEOUT_EN to bound hold time.
module gf180mcu_fd_sc_mcu9t5v0__rr_arb_func
   import gf180mcu_fd_sc_mcu9t5v0__arb_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int IDXW     = $clog2(ARB_N),
   parameter int MAX_HOLD = ARB_MAX_HOLD
) (
   input logic CLK,
   input logic RN,
   gf180mcu_fd_sc_mcu9t5v0__rr_arb_func_if.slave bus
);

   if (N < 2 || N > ARB_N_MAX || IDXW != $clog2(N) || MAX_HOLD < 1)
   begin : g_bad_cfg
      $error("rr_arb_func: unsupported parameter set");
   end

   arb_state_t      r_state;
   arb_state_t      w_state_nxt;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] w_ptr_nxt;
   logic [N-1:0]    r_gnt;
   logic [N-1:0]    w_gnt_nxt;
   logic [IDXW-1:0] r_idx;
   logic [IDXW-1:0] w_idx_nxt;
   logic            r_vld;
   logic            w_vld_nxt;
   logic            r_tout;
   logic            w_tout_nxt;

   logic [IDXW-1:0] w_ptr_inc;
   logic [IDXW-1:0] w_arb_ptr;
   logic [N-1:0]    w_req_arb;
   logic            w_rel;
   logic            w_tout_now;
   logic [N-1:0]    w_pick_oh;
   logic [IDXW-1:0] w_pick_idx;
   logic            w_pick_any;

   assign w_ptr_inc = (r_idx == IDXW'(N - 1)) ? '0 : r_idx + IDXW'(1);

   assign w_rel = bus.LAST | ~bus.REQ[r_idx] | w_tout_now;

   // On release the holder drops to lowest priority for this same edge.
   always_comb begin
      w_arb_ptr = r_ptr;
      w_req_arb = bus.REQ;
      if (r_state == BUSY) begin
         w_arb_ptr = w_ptr_inc;
         if (bus.LAST || w_tout_now) begin
            w_req_arb[r_idx] = 1'b0;
         end
      end
   end

   gf180mcu_fd_sc_mcu9t5v0__rr_pick_func #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .i_req (w_req_arb),
      .i_ptr (w_arb_ptr),
      .o_oh  (w_pick_oh),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      w_idx_nxt   = r_idx;
      w_vld_nxt   = r_vld;
      w_tout_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = BUSY;
               w_gnt_nxt   = w_pick_oh;
               w_idx_nxt   = w_pick_idx;
               w_vld_nxt   = 1'b1;
            end
         end
         BUSY: begin
            if (w_rel) begin
               w_ptr_nxt  = w_ptr_inc;
               w_tout_nxt = w_tout_now;
               if (w_pick_any) begin
                  w_gnt_nxt = w_pick_oh;
                  w_idx_nxt = w_pick_idx;
                  w_vld_nxt = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_gnt_nxt   = '0;
                  w_idx_nxt   = '0;
                  w_vld_nxt   = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_vld   <= 1'b0;
         r_tout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_idx   <= w_idx_nxt;
         r_vld   <= w_vld_nxt;
         r_tout  <= w_tout_nxt;
      end
   end

`ifdef GF180MCU_FD_SC_MCU9T5V0__RR_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] r_hold;
   logic              w_new_grant;

   assign w_new_grant = (w_state_nxt == BUSY) &&
                        ((r_state == IDLE) || w_rel);

   // r_hold is the number of completed cycles of the current grant.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_hold <= '0;
      end else if (w_new_grant) begin
         r_hold <= '0;
      end else if (r_state == BUSY) begin
         r_hold <= r_hold + HOLD_W'(1);
      end
   end

   assign w_tout_now = (r_state == BUSY) &&
                       (r_hold == HOLD_W'(MAX_HOLD - 1));
`else
   assign w_tout_now = 1'b0;
`endif

   assign bus.GNT     = r_gnt;
   assign bus.GNT_VLD = r_vld;
   assign bus.GNT_IDX = r_idx;
   assign bus.TIMEOUT = r_tout;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rr_arb_func.sv
// Directed scoreboard bench for the round-robin arbiter.
module tb_gf180mcu_fd_sc_mcu9t5v0__rr_arb_func;

   localparam int N        = 4;
   localparam int IDXW     = 2;
   localparam int MAX_HOLD = 16;

   typedef struct packed {
      logic [N-1:0]    gnt;
      logic            vld;
      logic [IDXW-1:0] idx;
      logic            tout;
   } exp_t;

   logic CLK = 1'b0;
   logic RN;

   gf180mcu_fd_sc_mcu9t5v0__rr_arb_func_if #(
      .N    (N),
      .IDXW (IDXW)
   ) bus ();

   gf180mcu_fd_sc_mcu9t5v0__rr_arb_func #(
      .N        (N),
      .IDXW     (IDXW),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .CLK (CLK),
      .RN  (RN),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(input logic [N-1:0] g, input logic t);
      exp_t e;
      e.gnt  = g;
      e.vld  = |g;
      e.idx  = '0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) e.idx = IDXW'(i);
      end
      e.tout = t;
      return e;
   endfunction

   task automatic check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         checks++;
         assert (bus.GNT === e.gnt) else begin
            errors++;
            $error("FAIL %s gnt: observed %b expected %b", tag, bus.GNT, e.gnt);
         end
         checks++;
         assert (bus.GNT_VLD === e.vld) else begin
            errors++;
            $error("FAIL %s vld: observed %b expected %b", tag, bus.GNT_VLD, e.vld);
         end
         checks++;
         assert (bus.GNT_IDX === e.idx) else begin
            errors++;
            $error("FAIL %s idx: observed %0d expected %0d", tag, bus.GNT_IDX, e.idx);
         end
         checks++;
         assert (bus.TIMEOUT === e.tout) else begin
            errors++;
            $error("FAIL %s tout: observed %b expected %b", tag, bus.TIMEOUT, e.tout);
         end
         checks++;
         assert ($onehot0(bus.GNT) === 1'b1) else begin
            errors++;
            $error("FAIL %s onehot: observed %b expected at most one bit", tag, bus.GNT);
         end
      end
   endtask

   task automatic step(
      input logic [N-1:0] req,
      input logic         last,
      input logic [N-1:0] g,
      input logic         t,
      input string        tag
   );
      bus.REQ  = req;
      bus.LAST = last;
      sb.push_back(mk(g, t));
      @(posedge CLK);
      #1;
      check(tag);
   endtask

   task automatic async_reset(input string tag);
      RN = 1'b0;
      sb.push_back(mk('0, 1'b0));
      #1;
      check(tag);
      #1;
      RN = 1'b1;
   endtask

   initial begin
      RN       = 1'b0;
      bus.REQ  = 4'b1111;
      bus.LAST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      sb.push_back(mk('0, 1'b0));
      check("rst_hold");
      RN = 1'b1;

      step(4'b1111, 1'b0, 4'b0001, 1'b0, "rst_first");
      step(4'b1111, 1'b1, 4'b0010, 1'b0, "rot1");
      step(4'b1111, 1'b1, 4'b0100, 1'b0, "rot2");
      step(4'b1111, 1'b1, 4'b1000, 1'b0, "rot3");
      step(4'b1111, 1'b1, 4'b0001, 1'b0, "rot_wrap");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "rel_idle");

      step(4'b1010, 1'b0, 4'b0010, 1'b0, "idle_pick");
      step(4'b1010, 1'b0, 4'b0010, 1'b0, "hold");
      step(4'b1010, 1'b1, 4'b1000, 1'b0, "switch3");
      step(4'b0100, 1'b1, 4'b0100, 1'b0, "to2");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_req");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "last_idle");
      step(4'b1001, 1'b0, 4'b1000, 1'b0, "ptr3");
      step(4'b1001, 1'b1, 4'b0001, 1'b0, "ptr_wrap");
      step(4'b0100, 1'b1, 4'b0100, 1'b0, "hold2");

      async_reset("async_rst");
      step(4'b0101, 1'b0, 4'b0001, 1'b0, "ptr_restart");
      step(4'b0100, 1'b1, 4'b0100, 1'b0, "after_rst");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle_again");

      RN = 1'b0;
      bus.REQ = 4'b1010;
      @(posedge CLK);
      #1;
      sb.push_back(mk('0, 1'b0));
      check("rst_req");
      RN = 1'b1;
      step(4'b1010, 1'b0, 4'b0010, 1'b0, "t2_grant");
      step(4'b1010, 1'b1, 4'b1000, 1'b0, "t2_nobubble");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t2_release");

`ifdef GF180MCU_FD_SC_MCU9T5V0__RR_ARB_TIMEOUT_EN
      for (int c = 0; c < MAX_HOLD; c++) begin
         step(4'b0010, 1'b0, 4'b0010, 1'b0, "to_hold");
      end
      step(4'b0010, 1'b0, 4'b0000, 1'b1, "to_revoke");
      step(4'b0011, 1'b0, 4'b0001, 1'b0, "to_next");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "to_release");
`else
      for (int c = 0; c < MAX_HOLD + 4; c++) begin
         step(4'b0010, 1'b0, 4'b0010, 1'b0, "nto_hold");
      end
      step(4'b0011, 1'b0, 4'b0010, 1'b0, "nto_keep");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "nto_release");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of sequence");
      $fatal(1, "watchdog");
   end

endmodule
